// File: rtl/opb_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : opb_bus_arbiter
// Purpose  : Two-master round-robin arbiter and sequencer for the OPB
//            address-decoder port. Issues one single-cycle decoder strobe per
//            transaction, waits out the decoder read latency, captures the
//            read data and returns a one-cycle ACK to the owning master.
// Ports    : OPB_CLK                  clock, rising edge
//            OPB_RST_N                synchronous reset, active-low
//            M0_* / M1_*              master request/ack/data (M0 = host
//                                     bridge, M1 = status poller)
//            DEC_ADDR/RE/WE/WDATA     decoder strobe interface (registered)
//            DEC_DO                   decoder read-data return
//            GRANT                    one-hot owner, 00 when idle
//            BUSY                     high whenever not idle
// Params   : RD_LATENCY               DEC_RE cycle to valid DEC_DO, 1..4
// Revision : 1.0 - initial release
// ============================================================================
module opb_bus_arbiter #(
    parameter int RD_LATENCY = 1
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST_N,

    input  logic        M0_REQ,
    input  logic        M0_WR,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_WDATA,
    output logic        M0_ACK,
    output logic [31:0] M0_RDATA,

    input  logic        M1_REQ,
    input  logic        M1_WR,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_WDATA,
    output logic        M1_ACK,
    output logic [31:0] M1_RDATA,

    output logic [31:0] DEC_ADDR,
    output logic        DEC_RE,
    output logic        DEC_WE,
    output logic [31:0] DEC_WDATA,
    input  logic [31:0] DEC_DO,

    output logic [1:0]  GRANT,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RWAIT = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // The counter runs RD_LATENCY-1 down to 0, one RWAIT cycle per count.
    localparam logic [1:0] C_CNT_LOAD = 2'(RD_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_wr;
    logic [1:0]  r_cnt;
    logic        r_last_m1;
    logic [1:0]  r_grant;
    logic        r_busy;
    logic [31:0] r_dec_addr;
    logic [31:0] r_dec_wdata;
    logic        r_dec_re;
    logic        r_dec_we;
    logic        r_m0_ack;
    logic        r_m1_ack;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;

    logic        w_req_any;
    logic        w_pick_m1;
    logic        w_sel_wr;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;

    // M1 wins when it is the only requester, or on a tie when M0 was the
    // last master served. r_last_m1 resets to 1 so M0 wins the first tie.
    assign w_req_any   = M0_REQ | M1_REQ;
    assign w_pick_m1   = M1_REQ & (~M0_REQ | ~r_last_m1);
    assign w_sel_wr    = w_pick_m1 ? M1_WR    : M0_WR;
    assign w_sel_addr  = w_pick_m1 ? M1_ADDR  : M0_ADDR;
    assign w_sel_wdata = w_pick_m1 ? M1_WDATA : M0_WDATA;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge OPB_CLK) begin
        if (!OPB_RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = r_wr ? S_ACK : S_RWAIT;
            S_RWAIT: if (r_cnt == 2'd0) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath. Every output is loaded on the edge
    // that enters the state in which it must be visible, so strobes and
    // ACK line up exactly with the ISSUE and ACK states.
    // ------------------------------------------------------------------
    always_ff @(posedge OPB_CLK) begin
        if (!OPB_RST_N) begin
            r_wr        <= 1'b0;
            r_cnt       <= 2'd0;
            r_last_m1   <= 1'b1;
            r_grant     <= 2'b00;
            r_busy      <= 1'b0;
            r_dec_addr  <= 32'd0;
            r_dec_wdata <= 32'd0;
            r_dec_re    <= 1'b0;
            r_dec_we    <= 1'b0;
            r_m0_ack    <= 1'b0;
            r_m1_ack    <= 1'b0;
            r_m0_rdata  <= 32'd0;
            r_m1_rdata  <= 32'd0;
        end else begin
            // Strobes and ACKs are single-cycle pulses by default.
            r_dec_re <= 1'b0;
            r_dec_we <= 1'b0;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        // DEC_ADDR/DEC_WDATA double as the latched request,
                        // so later master-side changes are ignored.
                        r_grant     <= w_pick_m1 ? 2'b10 : 2'b01;
                        r_wr        <= w_sel_wr;
                        r_dec_addr  <= w_sel_addr;
                        r_dec_wdata <= w_sel_wdata;
                        r_dec_we    <= w_sel_wr;
                        r_dec_re    <= ~w_sel_wr;
                    end
                end
                S_ISSUE: begin
                    if (r_wr) begin
                        r_m0_ack <= r_grant[0];
                        r_m1_ack <= r_grant[1];
                    end else begin
                        r_cnt <= C_CNT_LOAD;
                    end
                end
                S_RWAIT: begin
                    if (r_cnt == 2'd0) begin
                        if (r_grant[1]) begin
                            r_m1_rdata <= DEC_DO;
                        end else begin
                            r_m0_rdata <= DEC_DO;
                        end
                        r_m0_ack <= r_grant[0];
                        r_m1_ack <= r_grant[1];
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_ACK: begin
                    r_last_m1 <= r_grant[1];
                    r_grant   <= 2'b00;
                end
                default: ;
            endcase

            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    assign DEC_ADDR  = r_dec_addr;
    assign DEC_WDATA = r_dec_wdata;
    assign DEC_RE    = r_dec_re;
    assign DEC_WE    = r_dec_we;
    assign M0_ACK    = r_m0_ack;
    assign M1_ACK    = r_m1_ack;
    assign M0_RDATA  = r_m0_rdata;
    assign M1_RDATA  = r_m1_rdata;
    assign GRANT     = r_grant;
    assign BUSY      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_opb_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_opb_bus_arbiter
// Purpose  : Scoreboard bench for opb_bus_arbiter. Stimulus predicts each
//            transaction (order, address, data, read result) into a queue;
//            a negedge monitor pops entries on decoder strobes and checks
//            strobes, ACK timing and returned data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opb_bus_arbiter;

    localparam int RD_LAT = 3;

    logic        OPB_CLK = 1'b0;
    logic        OPB_RST_N = 1'b0;
    logic        M0_REQ, M0_WR, M0_ACK;
    logic [31:0] M0_ADDR, M0_WDATA, M0_RDATA;
    logic        M1_REQ, M1_WR, M1_ACK;
    logic [31:0] M1_ADDR, M1_WDATA, M1_RDATA;
    logic [31:0] DEC_ADDR, DEC_WDATA, DEC_DO;
    logic        DEC_RE, DEC_WE;
    logic [1:0]  GRANT;
    logic        BUSY;

    always #5 OPB_CLK = ~OPB_CLK;

    opb_bus_arbiter #(.RD_LATENCY(RD_LAT)) dut (
        .OPB_CLK  (OPB_CLK),
        .OPB_RST_N(OPB_RST_N),
        .M0_REQ   (M0_REQ),
        .M0_WR    (M0_WR),
        .M0_ADDR  (M0_ADDR),
        .M0_WDATA (M0_WDATA),
        .M0_ACK   (M0_ACK),
        .M0_RDATA (M0_RDATA),
        .M1_REQ   (M1_REQ),
        .M1_WR    (M1_WR),
        .M1_ADDR  (M1_ADDR),
        .M1_WDATA (M1_WDATA),
        .M1_ACK   (M1_ACK),
        .M1_RDATA (M1_RDATA),
        .DEC_ADDR (DEC_ADDR),
        .DEC_RE   (DEC_RE),
        .DEC_WE   (DEC_WE),
        .DEC_WDATA(DEC_WDATA),
        .DEC_DO   (DEC_DO),
        .GRANT    (GRANT),
        .BUSY     (BUSY)
    );

    typedef struct {
        int          m;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    bit          cur_v = 1'b0;
    int          cur_cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_strobe = -10;
    int          last_m = 1;
    logic [31:0] exp_rd [2];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dec_mem [logic [31:0]];
    logic [31:0] pipe [RD_LAT];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] raddr();
        return 32'h0008_0000 + 32'(4 * $urandom_range(0, 7));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge OPB_CLK) cyc <= cyc + 1;

    // Decoder model: registered read with RD_LAT cycles of latency.
    always @(posedge OPB_CLK) begin
        if (DEC_WE) dec_mem[DEC_ADDR] = DEC_WDATA;
        for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= DEC_RE ? (dec_mem.exists(DEC_ADDR) ? dec_mem[DEC_ADDR] : dflt(DEC_ADDR))
                          : 32'h0;
    end
    assign DEC_DO = pipe[RD_LAT-1];

    // Monitor / scoreboard
    always @(negedge OPB_CLK) begin
        if (OPB_RST_N) begin
            if (DEC_RE || DEC_WE) begin
                chk("strobe_exclusive", 32'(DEC_RE & DEC_WE), 32'd0);
                chk("strobe_not_adjacent", 32'((cyc - last_strobe) > 1), 32'd1);
                last_strobe = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_strobe: addr %h with no expected transaction", DEC_ADDR);
                end else begin
                    cur = exp_q.pop_front();
                    cur_v = 1'b1;
                    cur_cyc = cyc;
                    chk("issue_grant", 32'(GRANT), (cur.m == 0) ? 32'd1 : 32'd2);
                    chk("issue_we", 32'(DEC_WE), 32'(cur.wr));
                    chk("issue_re", 32'(DEC_RE), 32'(!cur.wr));
                    chk("issue_addr", DEC_ADDR, cur.addr);
                    chk("issue_wdata", DEC_WDATA, cur.wdata);
                    chk("issue_busy", 32'(BUSY), 32'd1);
                end
            end
            if (M0_ACK || M1_ACK) begin
                if (!cur_v) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_ack: m0 %b m1 %b with nothing issued", M0_ACK, M1_ACK);
                end else begin
                    chk("ack_m0", 32'(M0_ACK), 32'(cur.m == 0));
                    chk("ack_m1", 32'(M1_ACK), 32'(cur.m == 1));
                    chk("ack_latency", 32'(cyc - cur_cyc), cur.wr ? 32'd1 : 32'(1 + RD_LAT));
                    chk("ack_grant", 32'(GRANT), (cur.m == 0) ? 32'd1 : 32'd2);
                    if (!cur.wr) exp_rd[cur.m] = cur.rdata;
                    chk("m0_rdata", M0_RDATA, exp_rd[0]);
                    chk("m1_rdata", M1_RDATA, exp_rd[1]);
                    cur_v = 1'b0;
                end
            end
        end
    end

    // Reference model: round-robin order is decided here, and read results
    // come from a flat memory updated in that predicted order.
    task automatic predict(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.m = m; t.wr = wr; t.addr = a; t.wdata = d; t.rdata = 32'd0;
        if (wr) ref_mem[a] = d;
        else    t.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        exp_q.push_back(t);
        last_m = m;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ref_mem[a] = d;
        dec_mem[a] = d;
    endtask

    task automatic drive(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            M0_REQ = 1'b1; M0_WR = wr; M0_ADDR = a; M0_WDATA = d;
        end else begin
            M1_REQ = 1'b1; M1_WR = wr; M1_ADDR = a; M1_WDATA = d;
        end
    endtask

    // Each master drops REQ on the negedge where it sees its ACK.
    task automatic wait_acks(input bit need0, input bit need1, input int budget);
        bit p0 = need0;
        bit p1 = need1;
        int k = 0;
        while ((p0 || p1) && k < budget) begin
            @(negedge OPB_CLK);
            k++;
            if (M0_ACK && p0) begin p0 = 1'b0; M0_REQ = 1'b0; end
            if (M1_ACK && p1) begin p1 = 1'b0; M1_REQ = 1'b0; end
        end
        if (p0 || p1) begin
            n_tests++; n_fail++;
            $display("FAIL ack_timeout: pending m0 %b m1 %b after %0d cycles", p0, p1, budget);
            M0_REQ = 1'b0; M1_REQ = 1'b0;
        end
        @(negedge OPB_CLK);
    endtask

    // Both/one masters hold REQ across ACKs; stop after n ACKs.
    task automatic hold_wait(input int n, input bit gap3);
        int got = 0;
        int k = 0;
        int prev = -1;
        while (got < n && k < 200) begin
            @(negedge OPB_CLK);
            k++;
            if (M0_ACK || M1_ACK) begin
                got++;
                if (gap3 && prev >= 0) chk("hold_ack_spacing", 32'(cyc - prev), 32'd3);
                prev = cyc;
                if (got == n) begin M0_REQ = 1'b0; M1_REQ = 1'b0; end
            end
        end
        if (got < n) begin
            n_tests++; n_fail++;
            $display("FAIL hold_timeout: got %0d acks required %0d", got, n);
            M0_REQ = 1'b0; M1_REQ = 1'b0;
        end
        @(negedge OPB_CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m0_ack"},    32'(M0_ACK), 32'd0);
        chk({tag, "_m1_ack"},    32'(M1_ACK), 32'd0);
        chk({tag, "_m0_rdata"},  M0_RDATA, 32'd0);
        chk({tag, "_m1_rdata"},  M1_RDATA, 32'd0);
        chk({tag, "_dec_addr"},  DEC_ADDR, 32'd0);
        chk({tag, "_dec_wdata"}, DEC_WDATA, 32'd0);
        chk({tag, "_dec_re"},    32'(DEC_RE), 32'd0);
        chk({tag, "_dec_we"},    32'(DEC_WE), 32'd0);
        chk({tag, "_grant"},     32'(GRANT), 32'd0);
        chk({tag, "_busy"},      32'(BUSY), 32'd0);
    endtask

    task automatic rand_round();
        int          sel = int'($urandom_range(1, 3));
        bit          u0 = (sel == 1) || (sel == 3);
        bit          u1 = (sel == 2) || (sel == 3);
        bit          w0 = 1'($urandom_range(0, 1));
        bit          w1 = 1'($urandom_range(0, 1));
        logic [31:0] a0 = raddr();
        logic [31:0] a1 = raddr();
        logic [31:0] d0 = $urandom;
        logic [31:0] d1 = $urandom;
        bit          pert = (sel != 3) && ($urandom_range(0, 1) == 1);
        if (sel == 3) begin
            if (last_m == 1) begin
                predict(0, w0, a0, d0); predict(1, w1, a1, d1);
            end else begin
                predict(1, w1, a1, d1); predict(0, w0, a0, d0);
            end
        end else if (u0) begin
            predict(0, w0, a0, d0);
        end else begin
            predict(1, w1, a1, d1);
        end
        if (u0) drive(0, w0, a0, d0);
        if (u1) drive(1, w1, a1, d1);
        if (pert) begin
            // One cycle after the grant edge: the arbiter must ignore this.
            @(negedge OPB_CLK);
            if (u0) begin M0_WR = ~w0; M0_ADDR = ~a0; M0_WDATA = ~d0; end
            else    begin M1_WR = ~w1; M1_ADDR = ~a1; M1_WDATA = ~d1; end
        end
        wait_acks(u0, u1, 60);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        M0_REQ = 1'b0; M0_WR = 1'b0; M0_ADDR = 32'd0; M0_WDATA = 32'd0;
        M1_REQ = 1'b0; M1_WR = 1'b0; M1_ADDR = 32'd0; M1_WDATA = 32'd0;
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        OPB_RST_N = 1'b0;
        repeat (3) @(negedge OPB_CLK);
        chk_all_zero("reset");
        OPB_RST_N = 1'b1;
        @(negedge OPB_CLK);

        // Both masters holding REQ from reset: M0, M1, M0, M1.
        preload(32'h0008_0004, 32'hCAFE_0001);
        predict(0, 1'b1, 32'h0006_0010, 32'h1111_2222);
        predict(1, 1'b0, 32'h0008_0004, 32'd0);
        predict(0, 1'b1, 32'h0006_0010, 32'h1111_2222);
        predict(1, 1'b0, 32'h0008_0004, 32'd0);
        drive(0, 1'b1, 32'h0006_0010, 32'h1111_2222);
        drive(1, 1'b0, 32'h0008_0004, 32'd0);
        hold_wait(4, 1'b0);

        // Single M0 write.
        predict(0, 1'b1, 32'h0006_0000, 32'hA5A5_0003);
        drive(0, 1'b1, 32'h0006_0000, 32'hA5A5_0003);
        wait_acks(1'b1, 1'b0, 30);

        // M1 read of a known location.
        preload(32'h0008_0010, 32'h1234_5678);
        predict(1, 1'b0, 32'h0008_0010, 32'd0);
        drive(1, 1'b0, 32'h0008_0010, 32'd0);
        wait_acks(1'b0, 1'b1, 30);

        // M1 held continuously with writes: ACK every 3 cycles.
        for (int i = 0; i < 3; i++) predict(1, 1'b1, 32'h0007_0000, 32'hBEEF_0007);
        drive(1, 1'b1, 32'h0007_0000, 32'hBEEF_0007);
        hold_wait(3, 1'b1);

        // Address change one cycle after the grant is ignored.
        predict(0, 1'b1, 32'h0002_0000, 32'h0000_0022);
        drive(0, 1'b1, 32'h0002_0000, 32'h0000_0022);
        @(negedge OPB_CLK);
        M0_ADDR = 32'h0001_0000;
        wait_acks(1'b1, 1'b0, 30);

        // Reset while the read is waiting on the decoder.
        predict(0, 1'b0, 32'h0008_0008, 32'd0);
        drive(0, 1'b0, 32'h0008_0008, 32'd0);
        @(negedge OPB_CLK);            // ISSUE
        @(negedge OPB_CLK);            // first RWAIT cycle
        OPB_RST_N = 1'b0;
        M0_REQ = 1'b0;
        @(negedge OPB_CLK);
        cur_v = 1'b0;
        last_m = 1;
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        chk_all_zero("midreset");
        OPB_RST_N = 1'b1;
        for (int i = 0; i < RD_LAT + 2; i++) begin
            @(negedge OPB_CLK);
            chk("no_ack_after_reset", 32'(M0_ACK | M1_ACK), 32'd0);
        end
        predict(0, 1'b0, 32'h0008_0010, 32'd0);
        drive(0, 1'b0, 32'h0008_0010, 32'd0);
        wait_acks(1'b1, 1'b0, 30);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) rand_round();

        repeat (4) @(negedge OPB_CLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("nothing_pending", 32'(cur_v), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/opb_bus_arbiter.md
Name: opb_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the OPB address-decoder port.
- Accepts single-word read/write requests from two masters: M0 is the host bridge, M1 is the periodic status poller.
- Grants one request at a time using round-robin priority.
- Drives DEC_ADDR/DEC_RE/DEC_WE/DEC_WDATA for exactly one cycle per transaction, waits out the decoder's registered read latency, captures DEC_DO and returns it to the granted master with a one-cycle ACK.

Parameters:
- RD_LATENCY, 1, cycles from the DEC_RE cycle to valid DEC_DO; legal range 1..4.

Ports:
- OPB_CLK  in  1  clock; all logic on rising edge.
- OPB_RST_N  in  1  synchronous reset, active-low.
- M0_REQ  in  1  master 0 request; held until M0_ACK.
- M0_WR  in  1  1=write, 0=read; valid with M0_REQ.
- M0_ADDR  in  32  master 0 address.
- M0_WDATA  in  32  master 0 write data.
- M0_ACK  out  1  one-cycle completion pulse to master 0.
- M0_RDATA  out  32  master 0 read data; valid while M0_ACK is high, then held.
- M1_REQ, M1_WR, M1_ADDR, M1_WDATA, M1_ACK, M1_RDATA  same widths and meanings, for master 1.
- DEC_ADDR  out  32  address to decoder.
- DEC_RE  out  1  decoder read strobe.
- DEC_WE  out  1  decoder write strobe.
- DEC_WDATA  out  32  write data to decoder and slaves.
- DEC_DO  in  32  decoder read-data return.
- GRANT  out  2  one-hot current owner (bit0=M0, bit1=M1); 00 when idle.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset: on a rising edge with OPB_RST_N=0, all outputs go to 0 and state goes to IDLE. Any in-flight transaction is dropped; no ACK is issued for it. The round-robin pointer is set so that M0 wins the first tie.
- All outputs are registered.
- States: IDLE, ISSUE, RWAIT, ACK.
- IDLE:
  - Samples M0_REQ and M1_REQ. If neither is high, stay in IDLE.
  - If only one is high, grant it.
  - If both are high, grant the master not granted last.
  - On grant: latch that master's WR, ADDR and WDATA; set GRANT; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - DEC_ADDR and DEC_WDATA are driven from the latched values.
  - DEC_WE=1 for a write, DEC_RE=1 for a read; never both.
  - Write goes to ACK. Read goes to RWAIT with the wait counter loaded to RD_LATENCY-1.
- RWAIT (RD_LATENCY cycles): DEC_RE=0, DEC_WE=0. In the cycle where the counter is 0, register DEC_DO into the granted master's RDATA and go to ACK. Otherwise decrement the counter.
- ACK (1 cycle):
  - The granted master's ACK=1; the other master's ACK stays 0.
  - Update the round-robin pointer to the granted master.
  - Go to IDLE. GRANT clears on entry to IDLE.
- Latency from the REQ-sampled edge:
  - Write: DEC_WE at +1, ACK at +2.
  - Read: DEC_RE at +1, data captured at +1+RD_LATENCY, ACK at +2+RD_LATENCY.
- Master rules:
  - Hold REQ, WR, ADDR and WDATA stable until ACK. Changes after the grant are ignored, because the arbiter uses its latched copy.
  - Deasserting REQ before ACK does not abort; ACK is still issued.
  - If REQ is still high in the cycle after ACK, that is a new request and goes through normal arbitration.
- Back-to-back: minimum 1 IDLE cycle between transactions, so DEC strobes are never on adjacent cycles.
- DEC_ADDR and DEC_WDATA keep their last issued value outside ISSUE. DEC_RE and DEC_WE are 0 outside ISSUE.
- RDATA of the non-granted master is never modified. Write transactions leave the granted master's RDATA unchanged.
- Unmapped read: DEC_DO is captured as-is (undriven bits become X/Z in simulation). ACK timing is unchanged; there is no timeout.
- A request sampled in the same cycle as ACK is not serviced until IDLE.

Test Plan:
- Reset, then M0 write with ADDR=0x00060000, WDATA=0xA5A5_0003 -> DEC_WE=1 with DEC_ADDR=0x00060000 and DEC_WDATA=0xA5A5_0003 for exactly 1 cycle at +1; M0_ACK at +2; M1_ACK stays 0.
- RD_LATENCY=1, M1 read of 0x00080010 with DEC_DO=0x1234_5678 one cycle after DEC_RE -> M1_ACK at +3 with M1_RDATA=0x1234_5678; M0_RDATA stays 0. Repeat with RD_LATENCY=3 -> ACK at +5.
- M0 and M1 request together from reset, both holding REQ -> order is M0, M1, M0, M1; GRANT alternates 01, 10; no cycle has DEC_RE and DEC_WE both high.
- M1 held continuously, M0 idle -> M1 serviced every 3 cycles (write) with 1 IDLE gap between DEC_WE pulses; no starvation of M1.
- Drive OPB_RST_N=0 while in RWAIT -> next edge: all outputs 0, no ACK; the following M0 read completes normally.
- M0 changes ADDR to 0x00010000 one cycle after grant of 0x00020000 -> DEC_ADDR=0x00020000 in ISSUE.
